// File: rtl/wshb_arbiter.sv
// Two-requester Wishbone arbiter in front of one shared SDRAM slave. It also has
// a stall watchdog that answers err when the slave never acknowledges a strobe.
module wshb_arbiter #(
    parameter int PRIO0   = 0,
    parameter int TIMEOUT = 1024
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        s0_cyc,
    input  logic        s0_stb,
    input  logic        s0_we,
    input  logic [31:0] s0_adr,
    input  logic [31:0] s0_dat_ms,
    input  logic [3:0]  s0_sel,
    input  logic [2:0]  s0_cti,
    input  logic [1:0]  s0_bte,
    output logic        s0_ack,
    output logic        s0_err,
    output logic        s0_rty,
    output logic [31:0] s0_dat_sm,
    input  logic        s1_cyc,
    input  logic        s1_stb,
    input  logic        s1_we,
    input  logic [31:0] s1_adr,
    input  logic [31:0] s1_dat_ms,
    input  logic [3:0]  s1_sel,
    input  logic [2:0]  s1_cti,
    input  logic [1:0]  s1_bte,
    output logic        s1_ack,
    output logic        s1_err,
    output logic        s1_rty,
    output logic [31:0] s1_dat_sm,
    output logic        m_cyc,
    output logic        m_stb,
    output logic        m_we,
    output logic [31:0] m_adr,
    output logic [31:0] m_dat_ms,
    output logic [3:0]  m_sel,
    output logic [2:0]  m_cti,
    output logic [1:0]  m_bte,
    input  logic        m_ack,
    input  logic        m_err,
    input  logic        m_rty,
    input  logic [31:0] m_dat_sm,
    output logic [1:0]  grant
);

    // Wishbone classic handshake: cyc frames a requester's whole bus tenure, and a
    // transfer completes in any cycle where stb and ack (or err) are both high.
    // Ownership follows cyc only. Terminations pass through combinationally.
    typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;

    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic        last_served;
    logic        run;
    logic [15:0] stall_cnt;
    logic        own0;
    logic        own1;
    logic        sel_cyc;
    logic        sel_stb;
    logic        timeout;
    logic        stall_inc;

    assign own0      = (state == OWN0);
    assign own1      = (state == OWN1);
    assign sel_cyc   = (own0 & s0_cyc) | (own1 & s1_cyc);
    assign sel_stb   = (own0 & s0_stb) | (own1 & s1_stb);
    assign timeout   = sel_stb & ~m_ack & (stall_cnt == STALL_LAST);
    assign stall_inc = sel_cyc & sel_stb & ~m_ack & ~m_err & ~timeout;
    assign grant     = state;

    always_comb begin
        m_cyc    = 1'b0;
        m_stb    = 1'b0;
        m_we     = 1'b0;
        m_adr    = '0;
        m_dat_ms = '0;
        m_sel    = '0;
        m_cti    = '0;
        m_bte    = '0;
        if (own0) begin
            m_cyc    = s0_cyc;
            m_stb    = s0_stb & ~timeout;
            m_we     = s0_we;
            m_adr    = s0_adr;
            m_dat_ms = s0_dat_ms;
            m_sel    = s0_sel;
            m_cti    = s0_cti;
            m_bte    = s0_bte;
        end else if (own1) begin
            m_cyc    = s1_cyc;
            m_stb    = s1_stb & ~timeout;
            m_we     = s1_we;
            m_adr    = s1_adr;
            m_dat_ms = s1_dat_ms;
            m_sel    = s1_sel;
            m_cti    = s1_cti;
            m_bte    = s1_bte;
        end
    end

    // The non-owner sees a silent bus, so its stalled strobe can wait forever.
    assign s0_ack    = own0 & m_ack;
    assign s0_err    = own0 & (m_err | timeout);
    assign s0_rty    = own0 & m_rty;
    assign s0_dat_sm = own0 ? m_dat_sm : '0;
    assign s1_ack    = own1 & m_ack;
    assign s1_err    = own1 & (m_err | timeout);
    assign s1_rty    = own1 & m_rty;
    assign s1_dat_sm = own1 ? m_dat_sm : '0;

    // run holds off the first grant until one clean edge after reset is released.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            last_served <= 1'b1;
            run         <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            run       <= 1'b1;
            stall_cnt <= stall_inc ? stall_cnt + 16'd1 : '0;
            case (state)
                IDLE: begin
                    if (run) begin
                        if (s0_cyc && (!s1_cyc || PRIO0 != 0 || last_served)) begin
                            state       <= OWN0;
                            last_served <= 1'b0;
                        end else if (s1_cyc) begin
                            state       <= OWN1;
                            last_served <= 1'b1;
                        end
                    end
                end
                OWN0:    if (!s0_cyc) state <= IDLE;
                OWN1:    if (!s1_cyc) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
